// File: rtl/call_register.sv
// Elevator call register: edge-detects hall and car buttons, latches calls, clears serviced calls.
// Optional build macro CALL_REGISTER_CAR_CANCEL_EN: a second car-button press cancels that car call.
module call_register #(
    parameter int FLOORS = 7,
    parameter int FW     = 3,
    parameter int CW     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [2*FLOORS-1:0] hallPress,
    input  logic [FLOORS:1]     carPress,
    input  logic [FW-1:0]       currentFloor,
    input  logic [1:0]          currentDirection,
    input  logic                doorState,
    input  logic                move,
    output logic [2*FLOORS-1:0] hallCall,
    output logic [FLOORS:1]     carCall,
    output logic                callAbove,
    output logic                callBelow,
    output logic                callHere,
    output logic [CW-1:0]       pendingCount
);

    logic [2*FLOORS-1:0] hall_prev;
    logic [FLOORS:1]     car_prev;
    logic                post_reset;
    logic [2*FLOORS-1:0] hall_rise, hall_clr, hall_next;
    logic [FLOORS:1]     car_rise, car_clr, car_cancel, car_next;
    logic                any_call;
    int                  cur_floor;

    assign cur_floor = int'(currentFloor);

    // History is zero right after reset, so the first cycle out of reset is masked:
    // a button held through reset must not look like a fresh press.
    assign hall_rise = hallPress & ~hall_prev & {(2*FLOORS){~post_reset}};
    assign car_rise  = carPress  & ~car_prev  & {FLOORS{~post_reset}};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hall_clr   = '0;
        car_clr    = '0;
        car_cancel = '0;
        for (int f = 1; f <= FLOORS; f++) begin
            if (f == cur_floor) begin
                if (doorState) begin
                    car_clr[f] = 1'b1;
                    if (currentDirection == 2'b00) begin
                        hall_clr[2*f-2] = 1'b1;
                        hall_clr[2*f-1] = 1'b1;
                    end else begin
                        hall_clr[2*f-2] = currentDirection[0];
                        hall_clr[2*f-1] = currentDirection[1];
                    end
                end else if (!move) begin
                    car_clr[f] = 1'b1;
                end
            end
`ifdef CALL_REGISTER_CAR_CANCEL_EN
            else begin
                car_cancel[f] = car_rise[f] & carCall[f];
            end
`endif
        end
        // Clears are applied last so a same-cycle press never survives service.
        hall_next = (hallCall | hall_rise) & ~hall_clr;
        car_next  = (carCall | car_rise) & ~car_clr & ~car_cancel;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            hall_prev  <= '0;
            car_prev   <= '0;
            hallCall   <= '0;
            carCall    <= '0;
            post_reset <= 1'b1;
        end else begin
            hall_prev  <= hallPress;
            car_prev   <= carPress;
            post_reset <= 1'b0;
            if (enable) begin
                hallCall <= hall_next;
                carCall  <= car_next;
            end
        end
    end

    always_comb begin
        callAbove    = 1'b0;
        callBelow    = 1'b0;
        callHere     = 1'b0;
        any_call     = 1'b0;
        pendingCount = '0;
        for (int f = 1; f <= FLOORS; f++) begin
            any_call = hallCall[2*f-2] | hallCall[2*f-1] | carCall[f];
            if (f > cur_floor)  callAbove = callAbove | any_call;
            if (f < cur_floor)  callBelow = callBelow | any_call;
            if (f == cur_floor) callHere  = callHere  | any_call;
            pendingCount = pendingCount + CW'(hallCall[2*f-2]) + CW'(hallCall[2*f-1])
                         + CW'(carCall[f]);
        end
    end

endmodule

// File: tb/tb_call_register.sv
// Directed, table-driven bench for call_register with the default 7-floor configuration.
module tb_call_register;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [13:0] hallPress;
    logic [7:1]  carPress;
    logic [2:0]  currentFloor;
    logic [1:0]  currentDirection;
    logic        doorState;
    logic        move;
    logic [13:0] hallCall;
    logic [7:1]  carCall;
    logic        callAbove;
    logic        callBelow;
    logic        callHere;
    logic [4:0]  pendingCount;

`ifdef CALL_REGISTER_CAR_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    call_register #(.FLOORS(7), .FW(3), .CW(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .hallPress        (hallPress),
        .carPress         (carPress),
        .currentFloor     (currentFloor),
        .currentDirection (currentDirection),
        .doorState        (doorState),
        .move             (move),
        .hallCall         (hallCall),
        .carCall          (carCall),
        .callAbove        (callAbove),
        .callBelow        (callBelow),
        .callHere         (callHere),
        .pendingCount     (pendingCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [13:0] hall;
        logic [7:1]  car;
        logic [2:0]  floor;
        logic [1:0]  dir;
        logic        door;
        logic        mv;
        logic [13:0] e_hall;
        logic [7:1]  e_car;
        logic        e_above;
        logic        e_below;
        logic        e_here;
        logic [4:0]  e_cnt;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic en, input logic [13:0] hall,
                                input logic [7:1] car, input logic [2:0] floor,
                                input logic [1:0] dir, input logic door, input logic mv,
                                input logic [13:0] e_hall, input logic [7:1] e_car,
                                input logic e_above, input logic e_below, input logic e_here,
                                input logic [4:0] e_cnt);
        vec_t v;
        v.rst = rst;       v.en = en;         v.hall = hall;       v.car = car;
        v.floor = floor;   v.dir = dir;       v.door = door;       v.mv = mv;
        v.e_hall = e_hall; v.e_car = e_car;   v.e_above = e_above; v.e_below = e_below;
        v.e_here = e_here; v.e_cnt = e_cnt;
        return v;
    endfunction

    // Drive on the falling edge, let one rising edge pass, compare on the next falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        reset            = v.rst;
        enable           = v.en;
        hallPress        = v.hall;
        carPress         = v.car;
        currentFloor     = v.floor;
        currentDirection = v.dir;
        doorState        = v.door;
        move             = v.mv;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".hallCall"},     32'(hallCall),     32'(v.e_hall));
        check({tag, ".carCall"},      32'(carCall),      32'(v.e_car));
        check({tag, ".callAbove"},    32'(callAbove),    32'(v.e_above));
        check({tag, ".callBelow"},    32'(callBelow),    32'(v.e_below));
        check({tag, ".callHere"},     32'(callHere),     32'(v.e_here));
        check({tag, ".pendingCount"}, 32'(pendingCount), 32'(v.e_cnt));
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; enable = 1'b1; hallPress = '0; carPress = '0;
        currentFloor = 3'd1; currentDirection = 2'b00; doorState = 1'b0; move = 1'b1;

        //                rst en hall     car    fl dir dr mv   e_hall   e_car  ab be hr cnt
        tbl.push_back(mk(1, 1, 14'h000, 7'h00, 1, 0, 0, 1, 14'h000, 7'h00, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 1, 0, 0, 1, 14'h000, 7'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 14'h000, 7'h10, 1, 0, 0, 1, 14'h000, 7'h10, 1, 0, 0, 1)); // latch car 5
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 1, 0, 0, 1, 14'h000, 7'h10, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 14'h030, 7'h00, 1, 0, 0, 1, 14'h030, 7'h10, 1, 0, 0, 3)); // floor 3 up+down
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 3, 1, 1, 1, 14'h020, 7'h10, 1, 0, 1, 2)); // clear up only
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 3, 1, 0, 1, 14'h020, 7'h10, 1, 0, 1, 2)); // moving: hold
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 0, 0, 1, 1, 14'h020, 7'h10, 1, 0, 0, 2)); // floor 0
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 7, 0, 0, 1, 14'h020, 7'h10, 0, 1, 0, 2)); // top floor
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 3, 0, 1, 1, 14'h000, 7'h10, 1, 0, 0, 1)); // idle: both
        tbl.push_back(mk(0, 1, 14'h100, 7'h00, 5, 0, 0, 0, 14'h100, 7'h00, 0, 0, 1, 1)); // close+hold
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 5, 0, 0, 1, 14'h100, 7'h00, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 14'h000, 7'h02, 5, 0, 1, 1, 14'h100, 7'h00, 0, 0, 1, 1)); // enable low
        tbl.push_back(mk(0, 1, 14'h000, 7'h02, 5, 0, 0, 1, 14'h100, 7'h00, 0, 0, 1, 1)); // edge lost
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 5, 0, 0, 1, 14'h100, 7'h00, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 14'h000, 7'h02, 5, 0, 0, 1, 14'h100, 7'h02, 0, 1, 1, 2));
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 5, 1, 1, 1, 14'h000, 7'h02, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 14'h000, 7'h08, 4, 0, 1, 1, 14'h000, 7'h02, 0, 1, 0, 1)); // collision
        tbl.push_back(mk(0, 1, 14'h000, 7'h00, 4, 0, 0, 1, 14'h000, 7'h02, 0, 1, 0, 1));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // Held hall button at floor 1 up, serviced in its fifth cycle.
        for (int c = 0; c < 10; c++) begin
            if (c < 4)
                run_vec(mk(0, 1, 14'h001, 7'h00, 1, 0, 0, 1, 14'h001, 7'h02, 1, 0, 1, 2),
                        $sformatf("held%0d", c));
            else if (c == 4)
                run_vec(mk(0, 1, 14'h001, 7'h00, 1, 0, 1, 1, 14'h000, 7'h02, 1, 0, 0, 1),
                        $sformatf("held%0d", c));
            else
                run_vec(mk(0, 1, 14'h001, 7'h00, 1, 0, 0, 1, 14'h000, 7'h02, 1, 0, 0, 1),
                        $sformatf("held%0d", c));
        end
        run_vec(mk(0, 1, 14'h000, 7'h00, 1, 0, 0, 1, 14'h000, 7'h02, 1, 0, 0, 1), "held_rel");
        run_vec(mk(0, 1, 14'h001, 7'h00, 1, 0, 0, 1, 14'h001, 7'h02, 1, 0, 1, 2), "held_new");
        run_vec(mk(0, 1, 14'h000, 7'h00, 1, 0, 1, 1, 14'h000, 7'h02, 1, 0, 0, 1), "held_clr");

        // Second press on car 6 while at floor 2.
        run_vec(mk(0, 1, 14'h000, 7'h20, 2, 0, 0, 1, 14'h000, 7'h22, 1, 0, 1, 2), "cancel_a");
        run_vec(mk(0, 1, 14'h000, 7'h00, 2, 0, 0, 1, 14'h000, 7'h22, 1, 0, 1, 2), "cancel_b");
        run_vec(mk(0, 1, 14'h000, 7'h20, 2, 0, 0, 1, 14'h000, CANCEL ? 7'h02 : 7'h22,
                   !CANCEL, 0, 1, CANCEL ? 5'd1 : 5'd2), "cancel_c");
        run_vec(mk(0, 1, 14'h000, 7'h00, 6, 0, 1, 1, 14'h000, 7'h02, 0, 1, 0, 1), "cancel_d");
        run_vec(mk(0, 1, 14'h000, 7'h00, 2, 0, 1, 1, 14'h000, 7'h00, 0, 0, 0, 0), "cancel_e");

        // Reset with calls at floors 2, 5, 7 and car button 2 held through it.
        run_vec(mk(0, 1, 14'h204, 7'h40, 1, 0, 0, 1, 14'h204, 7'h40, 1, 0, 0, 3), "rst_load");
        run_vec(mk(1, 1, 14'h000, 7'h02, 1, 0, 0, 1, 14'h000, 7'h00, 0, 0, 0, 0), "rst_pulse");
        for (int c = 0; c < 3; c++)
            run_vec(mk(0, 1, 14'h000, 7'h02, 1, 0, 0, 1, 14'h000, 7'h00, 0, 0, 0, 0),
                    $sformatf("rst_held%0d", c));
        run_vec(mk(0, 1, 14'h000, 7'h00, 1, 0, 0, 1, 14'h000, 7'h00, 0, 0, 0, 0), "rst_rel");
        run_vec(mk(0, 1, 14'h000, 7'h02, 1, 0, 0, 1, 14'h000, 7'h02, 1, 0, 0, 1), "rst_new");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
